// File: rtl/dmem_if.sv
// Datapath <-> data-memory responder bus, including the transmit port
// and the GPIO/error outputs.
interface dmem_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err;

    modport master (
        output memwrite, addr, wdata, tx_ready,
        input  rdata, gpio_out, tx_data, tx_valid, err
    );

    modport slave (
        input  memwrite, addr, wdata, tx_ready,
        output rdata, gpio_out, tx_data, tx_valid, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data memory for the single-cycle MIPS core: word RAM plus an MMIO window
// with a cycle counter, GPIO register, transmit FIFO and sticky status.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [27:0]   IO_BASE  = 28'hFFFF000;
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [31:0]                 mem [DEPTH_WORDS];
    logic [FIFO_DEPTH-1:0][7:0]  fifo_mem;
    logic [31:0]                 cycle_cnt;
    logic [7:0]                  gpio_q;
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic [CW-1:0]               count;
    logic                        ovf_q;
    logic                        mis_q;

    logic [AW-1:0] widx;
    logic          sel_ram;
    logic          sel_io;
    logic          sel_gpio;
    logic          sel_tx;
    logic          sel_status;
    logic          wr_ok;
    logic          mis_set;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          ovf_set;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Address decode on the full 32-bit address.
    assign widx       = bus.addr[AW+1:2];
    assign sel_ram    = (bus.addr[31:AW+2] == '0);
    assign sel_io     = (bus.addr[31:4] == IO_BASE);
    assign sel_gpio   = sel_io && (bus.addr[3:2] == 2'd1);
    assign sel_tx     = sel_io && (bus.addr[3:2] == 2'd2);
    assign sel_status = sel_io && (bus.addr[3:2] == 2'd3);

    // A misaligned store is suppressed everywhere and only raises misalign.
    assign wr_ok   = bus.memwrite && (bus.addr[1:0] == 2'b00);
    assign mis_set = bus.memwrite && (bus.addr[1:0] != 2'b00);

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign pop        = !fifo_empty && bus.tx_ready;
    assign push_req   = wr_ok && sel_tx;
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;

    // Combinational load path; byte offset is ignored.
    always_comb begin
        bus.rdata = '0;
        if (sel_ram) begin
            bus.rdata = mem[widx];
        end else if (sel_io) begin
            case (bus.addr[3:2])
                2'd0:    bus.rdata = cycle_cnt;
                2'd1:    bus.rdata = 32'(gpio_q);
                2'd2:    bus.rdata = 32'(count);
                default: bus.rdata = 32'({mis_q, ovf_q, fifo_empty, fifo_full});
            endcase
        end
    end

    // RAM is deliberately left out of reset so it survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (wr_ok && sel_ram) begin
            mem[widx] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            gpio_q    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_ok && sel_gpio) begin
                gpio_q <= bus.wdata[7:0];
            end
        end
    end

    // Transmit FIFO: circular buffer, push-while-full accepted only with a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.wdata[7:0];
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Sticky flags: a set event in the same cycle beats a write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (wr_ok && sel_status && bus.wdata[2]) begin
                ovf_q <= 1'b0;
            end
            if (mis_set) begin
                mis_q <= 1'b1;
            end else if (wr_ok && sel_status && bus.wdata[3]) begin
                mis_q <= 1'b0;
            end
        end
    end

    assign bus.gpio_out = gpio_q;
    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_mem[rd_ptr];
    assign bus.err      = ovf_q | mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: behavioural memory/FIFO model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_responder;
    localparam int unsigned DW = 64;
    localparam int unsigned FD = 4;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_GPIO   = 32'hFFFF_0004;
    localparam logic [31:0] A_TX     = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] ram_m [DW];
    bit          ram_v [DW];
    logic [31:0] cyc_m = '0;
    logic [7:0]  gpio_m = '0;
    logic [7:0]  q [$];
    bit          ovf_m = 1'b0;
    bit          mis_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected load value; returns 0 when the word is an unwritten RAM location.
    function automatic bit exp_rdata(input logic [31:0] a, output logic [31:0] v);
        int idx;
        v = '0;
        if (a < DW * 4) begin
            idx = int'(a >> 2);
            v = ram_m[idx];
            return ram_v[idx];
        end
        case ({a[31:2], 2'b00})
            A_CYCLE:  v = cyc_m;
            A_GPIO:   v = {24'd0, gpio_m};
            A_TX:     v = 32'(q.size());
            A_STATUS: v = {28'd0, mis_m, ovf_m, q.size() == 0, q.size() == FD};
            default:  v = '0;
        endcase
        return 1'b1;
    endfunction

    task automatic check_outputs();
        logic [31:0] v;
        if (exp_rdata(bus.addr, v)) chk("rdata", bus.rdata, v);
        chk("gpio_out", 32'(bus.gpio_out), 32'(gpio_m));
        chk("tx_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
        chk("err", 32'(bus.err), 32'(ovf_m | mis_m));
    endtask

    // Apply one rising edge to the model using the inputs presented this cycle.
    task automatic model_edge();
        bit pop;
        bit ovs;
        int idx;
        logic [31:0] a;
        a   = bus.addr;
        ovs = 1'b0;
        pop = (q.size() != 0) && bus.tx_ready;
        if (pop) void'(q.pop_front());
        if (bus.memwrite && a[1:0] == 2'b00) begin
            if (a < DW * 4) begin
                idx = int'(a >> 2);
                ram_m[idx] = bus.wdata;
                ram_v[idx] = 1'b1;
            end else if (a == A_GPIO) begin
                gpio_m = bus.wdata[7:0];
            end else if (a == A_TX) begin
                if (q.size() < FD) q.push_back(bus.wdata[7:0]);
                else ovs = 1'b1;
            end else if (a == A_STATUS) begin
                if (bus.wdata[2]) ovf_m = 1'b0;
                if (bus.wdata[3]) mis_m = 1'b0;
            end
        end
        if (ovs) ovf_m = 1'b1;
        if (bus.memwrite && a[1:0] != 2'b00) mis_m = 1'b1;
        cyc_m = cyc_m + 32'd1;
    endtask

    task automatic model_reset();
        cyc_m  = '0;
        gpio_m = '0;
        q.delete();
        ovf_m = 1'b0;
        mis_m = 1'b0;
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic to_pos();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        at_neg();
        to_pos();
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.memwrite = we;
        bus.addr     = a;
        bus.wdata    = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, a, d);
        step();
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, a, '0);
        at_neg();
        chk(name, bus.rdata, exp);
        to_pos();
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    logic [7:0] drain [4];

    initial begin
        drive(1'b0, A_CYCLE, '0);
        bus.tx_ready = 1'b0;
        #1;
        model_reset();
        chk("rst_rdata_cycle", bus.rdata, 32'd0);
        chk("rst_gpio", 32'(bus.gpio_out), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();

        // Counter: 10 edges after release
        repeat (9) step();
        read_chk("cycle_10", A_CYCLE, 32'd10);

        // RAM store / load, byte offset ignored
        wr(32'h14, 32'hCAFE_F00D);
        wr(32'h10, 32'hDEAD_BEEF);
        read_chk("ld_10", 32'h10, 32'hDEAD_BEEF);
        read_chk("ld_13", 32'h13, 32'hDEAD_BEEF);
        read_chk("ld_14", 32'h14, 32'hCAFE_F00D);
        read_chk("unmapped", 32'h1234_5678, 32'd0);

        // GPIO, misalign, write-1-to-clear
        wr(A_GPIO, 32'h0000_01A5);
        at_neg();
        chk("gpio_a5", 32'(bus.gpio_out), 32'hA5);
        to_pos();
        read_chk("gpio_rd", A_GPIO, 32'h0000_00A5);
        wr(32'hFFFF_0006, 32'h0000_00FF);
        read_chk("status_mis", A_STATUS, 32'h0000_000A);
        chk("err_mis", 32'(bus.err), 32'd1);
        read_chk("gpio_kept", A_GPIO, 32'h0000_00A5);
        wr(A_STATUS, 32'h8);
        at_neg();
        chk("err_cleared", 32'(bus.err), 32'd0);
        to_pos();

        // Fill beyond capacity with the sink stalled
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) wr(A_TX, 32'(i * 8'h11));
        read_chk("status_full_ovf", A_STATUS, 32'h0000_0005);
        read_chk("tx_count_4", A_TX, 32'd4);
        wr(A_STATUS, 32'h4);
        drain = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive(1'b0, A_STATUS, '0);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("drain_valid", 32'(bus.tx_valid), 32'd1);
            chk("drain_byte", 32'(bus.tx_data), 32'(drain[i]));
            to_pos();
        end
        at_neg();
        chk("drained_valid", 32'(bus.tx_valid), 32'd0);
        chk("status_empty", bus.rdata, 32'h0000_0002);
        to_pos();

        // Full FIFO with simultaneous pop and push
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(A_TX, 32'(i * 8'h11));
        bus.tx_ready = 1'b1;
        wr(A_TX, 32'h66);
        bus.tx_ready = 1'b0;
        read_chk("full_pop_push_cnt", A_TX, 32'd4);
        chk("full_pop_push_head", 32'(bus.tx_data), 32'h22);
        read_chk("full_pop_push_stat", A_STATUS, 32'h0000_0001);

        // Randomized traffic checked against the model every cycle
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0, 1, 2: a = {24'd0, 6'(32'($urandom_range(8, DW - 1))), 2'b00};
                3:       a = {24'd0, 6'(32'($urandom_range(8, DW - 1))), 2'($urandom)};
                4:       a = A_CYCLE;
                5:       a = A_GPIO;
                6, 7:    a = A_TX;
                8:       a = A_STATUS | 32'($urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00);
                default: a = 32'h8000_0000 | 32'($urandom);
            endcase
            drive(1'($urandom_range(0, 1)), a, $urandom);
            bus.tx_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end

        // Asynchronous reset with bytes queued
        bus.tx_ready = 1'b1;
        drive(1'b0, A_CYCLE, '0);
        repeat (6) step();
        bus.tx_ready = 1'b0;
        wr(A_TX, 32'hAA);
        wr(A_TX, 32'hBB);
        wr(A_GPIO, 32'h5A);
        wr(32'h21, 32'h0);
        drive(1'b0, A_CYCLE, '0);
        at_neg();
        chk("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
        chk("pre_rst_err", 32'(bus.err), 32'd1);
        chk("pre_rst_gpio", 32'(bus.gpio_out), 32'h5A);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("mid_rst_gpio", 32'(bus.gpio_out), 32'd0);
        chk("mid_rst_err", 32'(bus.err), 32'd0);
        chk("mid_rst_cycle", bus.rdata, 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        read_chk("ram_retained", 32'h10, 32'hDEAD_BEEF);
        read_chk("cycle_after_rst", A_CYCLE, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
